// File: rtl/rr_arb8.sv
// rr_arb8: eight-requester round-robin arbiter that holds a grant until the owner
// finishes or abandons its request. Optional ownership watchdog: RR_ARB8_TIMEOUT_EN.
module rr_arb8 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       err
);

  // Handshake: req[i] is a level request. Once granted, requester i owns the resource
  // until it pulses done or drops req[i]; both take effect at the same edge and leave
  // one IDLE cycle before the next owner. grant/grant_valid/grant_idx come from
  // registered state only.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic       err_q, err_d;

  logic [2:0] winner;
  logic [2:0] cand;
  logic       found;
  logic       any_req;
  logic       owner_req;
  logic       release_norm;
  logic       wd_expire;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rr_arb8: TIMEOUT must be in 2..255");
  end

  // First requester at or after ptr_q, wrapping modulo 8.
  always_comb begin
    winner = ptr_q;
    cand   = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign any_req      = |req;
  assign owner_req    = req[idx_q];
  assign release_norm = done || !owner_req;

`ifdef RR_ARB8_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt_q, wd_cnt_d;

  // Held at zero while idle so every new ownership starts counting from zero.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == S_IDLE) begin
      wd_cnt_d = 8'd0;
    end else if (!release_norm) begin
      wd_cnt_d = wd_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= 8'd0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign wd_expire = (state_q == S_GRANT) && (wd_cnt_q == WD_LAST);
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          idx_d   = winner;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // A normal release wins over the watchdog on the same cycle.
        if (release_norm) begin
          state_d = S_IDLE;
          ptr_d   = idx_q + 3'd1;
        end else if (wd_expire) begin
          state_d = S_IDLE;
          ptr_d   = idx_q + 3'd1;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign grant_valid = (state_q == S_GRANT);
  assign grant_idx   = idx_q;
  assign grant       = grant_valid ? (8'h01 << idx_q) : 8'h00;
  assign err         = err_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_grant_matches : assert property (@(posedge clk) disable iff (rst)
                                     grant_valid |-> grant[grant_idx]);

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed scenarios plus a randomized scoreboard run for rr_arb8.
// Each step pushes the expected {err, grant_valid, grant_idx, grant} before the edge.
module tb_rr_arb8;

`ifdef RR_ARB8_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
  localparam bit TB_WD      = 1'b1;
`else
  localparam int TB_TIMEOUT = 16;
  localparam bit TB_WD      = 1'b0;
`endif
  localparam int W = 13;

  // ---------------- clock / reset ----------------
  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [7:0] req  = 8'h00;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       err;

  always #5 clk = ~clk;

  rr_arb8 #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .err         (err)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] obs;
  int           n_checks = 0;
  int           n_pass   = 0;

  assign obs = {err, grant_valid, grant_idx, grant};

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish within 200000 time units, want finish");
    $fatal(1, "simulation time limit");
  end

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pack(input logic e, input logic v, input logic [2:0] i);
    return {e, v, i, (v ? (8'h01 << i) : 8'h00)};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic       t_rst [3] = '{1'b1, 1'b1, 1'b0};
    logic       t_v   [3] = '{1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 3; s++) begin
      rst  = t_rst[s];
      req  = 8'hFF;
      done = 1'b0;
      exp_q.push_back(pack(1'b0, t_v[s], 3'd0));
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL reset step %0d: got {err,v,idx,grant}=%h want %h", s, obs, exp_v);
      else
        n_pass++;
    end
  endtask

  // Owner 0 holds on entry; done each grant walks the pointer all the way round.
  task automatic test_rotation;
    logic [2:0] idx;
    for (int i = 1; i <= 16; i++) begin
      idx  = 3'((i - 1) / 2 + (i % 2 == 0 ? 1 : 0));
      req  = 8'hFF;
      done = (i % 2 == 1);
      exp_q.push_back(pack(1'b0, (i % 2 == 0), idx));
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL rotation step %0d: got {err,v,idx,grant}=%h want %h", i, obs, exp_v);
      else
        n_pass++;
    end
  endtask

  // Owner 0 on entry; grant 5 so ptr=6, then 8'h03 must wrap to 0 and then 1.
  task automatic test_wrap;
    logic [7:0] t_req  [6] = '{8'hFF, 8'h20, 8'h03, 8'h03, 8'h03, 8'h03};
    logic       t_done [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       t_v    [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] t_i    [6] = '{3'd0, 3'd5, 3'd5, 3'd0, 3'd0, 3'd1};
    for (int s = 0; s < 6; s++) begin
      req  = t_req[s];
      done = t_done[s];
      exp_q.push_back(pack(1'b0, t_v[s], t_i[s]));
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL wrap step %0d: got {err,v,idx,grant}=%h want %h", s, obs, exp_v);
      else
        n_pass++;
    end
  endtask

  // Owner 1 on entry; hand over to 2, then other requests must not preempt it.
  task automatic test_hold;
    int hold = (TB_TIMEOUT > 12) ? 10 : TB_TIMEOUT - 2;
    int n    = hold + 4;
    for (int s = 0; s < n; s++) begin
      done = (s == 0);
      if (s < 2)              req = 8'h04;
      else if (s < hold + 2)  req = 8'h0C;
      else                    req = 8'h08;
      if (s == 0)             exp_q.push_back(pack(1'b0, 1'b0, 3'd1));
      else if (s < hold + 2)  exp_q.push_back(pack(1'b0, 1'b1, 3'd2));
      else if (s == hold + 2) exp_q.push_back(pack(1'b0, 1'b0, 3'd2));
      else                    exp_q.push_back(pack(1'b0, 1'b1, 3'd3));
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL hold step %0d: got {err,v,idx,grant}=%h want %h", s, obs, exp_v);
      else
        n_pass++;
    end
  endtask

  // Owner 3 on entry; done together with owner drop must advance ptr only once.
  task automatic test_back_to_back;
    logic [7:0] t_req  [4] = '{8'h01, 8'h01, 8'h06, 8'h06};
    logic       t_done [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       t_v    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] t_i    [4] = '{3'd3, 3'd0, 3'd0, 3'd1};
    for (int s = 0; s < 4; s++) begin
      req  = t_req[s];
      done = t_done[s];
      exp_q.push_back(pack(1'b0, t_v[s], t_i[s]));
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL back_to_back step %0d: got {err,v,idx,grant}=%h want %h", s, obs, exp_v);
      else
        n_pass++;
    end
  endtask

  // Owner 1 on entry; grant 4, reset with done pending, then done-in-IDLE is ignored.
  task automatic test_mid_reset;
    logic       t_rst  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] t_req  [8] = '{8'h10, 8'h10, 8'h10, 8'h11, 8'h11, 8'h11, 8'h00, 8'h00};
    logic       t_done [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       t_v    [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] t_i    [8] = '{3'd1, 3'd4, 3'd0, 3'd0, 3'd0, 3'd4, 3'd4, 3'd4};
    for (int s = 0; s < 8; s++) begin
      rst  = t_rst[s];
      req  = t_req[s];
      done = t_done[s];
      exp_q.push_back(pack(1'b0, t_v[s], t_i[s]));
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL mid_reset step %0d: got {err,v,idx,grant}=%h want %h", s, obs, exp_v);
      else
        n_pass++;
    end
    rst = 1'b0;
  endtask

  // Owner 3 with req[3] held and no done: watchdog build forces release after
  // TIMEOUT cycles; default build must hold the grant indefinitely.
  task automatic test_watchdog;
    int n = TB_WD ? TB_TIMEOUT + 3 : 40;
    for (int s = 0; s < n; s++) begin
      rst  = (s == 0);
      req  = 8'h18;
      done = 1'b0;
      if (s == 0)                             exp_q.push_back(pack(1'b0, 1'b0, 3'd0));
      else if (!TB_WD || s <= TB_TIMEOUT)     exp_q.push_back(pack(1'b0, 1'b1, 3'd3));
      else if (s == TB_TIMEOUT + 1)           exp_q.push_back(pack(1'b1, 1'b0, 3'd3));
      else                                    exp_q.push_back(pack(1'b0, 1'b1, 3'd4));
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL watchdog step %0d: got {err,v,idx,grant}=%h want %h", s, obs, exp_v);
      else
        n_pass++;
    end
    rst = 1'b0;
  endtask

  // Random req/done against a behavioural reference of the arbiter.
  task automatic test_random;
    logic       m_gnt, m_err, found;
    logic [2:0] m_ptr, m_idx, c;
    int         m_wd;
    m_gnt = 1'b0; m_err = 1'b0; m_ptr = 3'd0; m_idx = 3'd0; m_wd = 0;
    for (int i = 0; i < 400; i++) begin
      rst = (i == 0);
      if ($urandom_range(0, 2) == 0) req = 8'($urandom_range(0, 255));
      done = ($urandom_range(0, 3) == 0);
      m_err = 1'b0;
      if (rst) begin
        m_gnt = 1'b0; m_ptr = 3'd0; m_idx = 3'd0; m_wd = 0;
      end else if (!m_gnt) begin
        if (req != 8'h00) begin
          found = 1'b0;
          for (int k = 0; k < 8; k++) begin
            c = m_ptr + 3'(k);
            if (!found && req[c]) begin
              m_idx = c;
              found = 1'b1;
            end
          end
          m_gnt = 1'b1;
          m_wd  = 0;
        end
      end else if (done || !req[m_idx]) begin
        m_gnt = 1'b0;
        m_ptr = m_idx + 3'd1;
      end else if (TB_WD && m_wd == TB_TIMEOUT - 1) begin
        m_gnt = 1'b0;
        m_ptr = m_idx + 3'd1;
        m_err = 1'b1;
      end else begin
        m_wd++;
      end
      exp_q.push_back(pack(m_err, m_gnt, m_idx));
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL random cycle %0d: got {err,v,idx,grant}=%h want %h", i, obs, exp_v);
      else
        n_pass++;
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_rotation();
    test_wrap();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_watchdog();
    test_random();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
